// File: rtl/fwrisc_trace_pkg.sv
// Shared types for the fwrisc trace-capture slice: the packed retire record
// and its width.
package fwrisc_trace_pkg;

  typedef struct packed {
    logic        gap;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rd_vld;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        m_vld;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
  } trace_rec_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/fwrisc_trace_capture_if.sv
// Tracer-side inputs and record-stream outputs of the trace capture block.
// The capture block is the slave; the tracer/consumer side is the master.
interface fwrisc_trace_capture_if #(
  parameter int CNT_W = 16
);
  import fwrisc_trace_pkg::*;

  logic             en;
  logic             clr;
  logic             ivalid;
  logic [31:0]      pc;
  logic [31:0]      instr;
  logic             rd_write;
  logic [5:0]       rd_waddr;
  logic [31:0]      rd_wdata;
  logic             mvalid;
  logic             mwrite;
  logic [31:0]      maddr;
  logic [31:0]      mdata;
  logic [3:0]       mstrb;
  logic             out_valid;
  logic             out_ready;
  trace_rec_t       out_rec;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow;

  modport slave (
    input  en, clr, ivalid, pc, instr, rd_write, rd_waddr, rd_wdata,
           mvalid, mwrite, maddr, mdata, mstrb, out_ready,
    output out_valid, out_rec, drop_cnt, overflow
  );

  modport master (
    output en, clr, ivalid, pc, instr, rd_write, rd_waddr, rd_wdata,
           mvalid, mwrite, maddr, mdata, mstrb, out_ready,
    input  out_valid, out_rec, drop_cnt, overflow
  );

endinterface

// File: rtl/fwrisc_trace_fifo.sv
// Generic synchronous FIFO with flush. Pointers carry one extra wrap bit so
// full and empty are distinguishable; the head output reads as zero when empty.
module fwrisc_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_wr_en = i_push && !i_clr && (!o_full || i_pop);
  assign w_rd_en = i_pop  && !i_clr && !o_empty;

  // NOTE: non-blocking assignments on every clocked register so all state
  // updates see pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; emptiness comes from the pointers and the
  // output mux hides stale entries.
  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/fwrisc_trace_capture.sv
// Packs each retired instruction with the rd and store it caused into one
// record, queues it, and counts records lost while the queue is full.
module fwrisc_trace_capture #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  fwrisc_trace_capture_if.slave  bus
);
  import fwrisc_trace_pkg::*;

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic             r_rd_vld;
  logic [5:0]       r_rd_addr;
  logic [31:0]      r_rd_data;
  logic             r_m_vld;
  logic [31:0]      r_m_addr;
  logic [31:0]      r_m_data;
  logic [3:0]       r_m_strb;
  logic             r_gap_pend;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_rd_in;
  logic             w_m_in;
  logic             w_commit;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_count;
  logic [TRACE_REC_W-1:0] w_head;
  trace_rec_t       w_rec;

  assign w_rd_in  = bus.en && bus.rd_write;
  assign w_m_in   = bus.en && bus.mvalid && bus.mwrite;
  assign w_commit = bus.en && bus.ivalid;
  assign w_pop    = !w_empty && bus.out_ready;

  assign w_push_ok = (w_count < DEPTH_CNT) || (w_full && w_pop);
  assign w_push    = w_commit && !bus.clr && w_push_ok;
  assign w_drop    = w_commit && !bus.clr && !w_push_ok;

  // NOTE: every field gets a default first so this block cannot infer a latch.
  always_comb begin
    w_rec       = '0;
    w_rec.gap   = r_gap_pend;
    w_rec.pc    = bus.pc;
    w_rec.instr = bus.instr;
    // A write arriving with the retire takes precedence over the held slot.
    if (w_rd_in) begin
      w_rec.rd_vld  = 1'b1;
      w_rec.rd_addr = bus.rd_waddr;
      w_rec.rd_data = bus.rd_wdata;
    end else if (r_rd_vld) begin
      w_rec.rd_vld  = 1'b1;
      w_rec.rd_addr = r_rd_addr;
      w_rec.rd_data = r_rd_data;
    end
    if (w_m_in) begin
      w_rec.m_vld  = 1'b1;
      w_rec.m_addr = bus.maddr;
      w_rec.m_data = bus.mdata;
      w_rec.m_strb = bus.mstrb;
    end else if (r_m_vld) begin
      w_rec.m_vld  = 1'b1;
      w_rec.m_addr = r_m_addr;
      w_rec.m_data = r_m_data;
      w_rec.m_strb = r_m_strb;
    end
  end

  // Pending slots: a commit consumes them, including any same-cycle write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_vld  <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_m_vld   <= 1'b0;
      r_m_addr  <= '0;
      r_m_data  <= '0;
      r_m_strb  <= '0;
    end else if (bus.clr || w_commit) begin
      r_rd_vld <= 1'b0;
      r_m_vld  <= 1'b0;
    end else begin
      if (w_rd_in) begin
        r_rd_vld  <= 1'b1;
        r_rd_addr <= bus.rd_waddr;
        r_rd_data <= bus.rd_wdata;
      end
      if (w_m_in) begin
        r_m_vld  <= 1'b1;
        r_m_addr <= bus.maddr;
        r_m_data <= bus.mdata;
        r_m_strb <= bus.mstrb;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
      r_gap_pend <= 1'b0;
    end else if (bus.clr) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
      r_gap_pend <= 1'b0;
    end else if (w_drop) begin
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      r_overflow <= 1'b1;
      r_gap_pend <= 1'b1;
    end else if (w_push) begin
      r_gap_pend <= 1'b0;
    end
  end

  fwrisc_trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_clr   (bus.clr),
    .i_push  (w_push),
    .i_wdata (w_rec),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.out_valid = !w_empty;
  assign bus.out_rec   = trace_rec_t'(w_head);
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_fwrisc_trace_capture.sv
// Directed bench for fwrisc_trace_capture: retire/bypass/store records,
// overflow and gap marking, full-with-pop, async reset and flush.
module tb_fwrisc_trace_capture;
  import fwrisc_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  fwrisc_trace_capture_if #(.CNT_W(CNT_W)) bus ();

  fwrisc_trace_capture #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Payload fields of an invalid slot carry no meaning, so they are masked.
  function automatic trace_rec_t mask(input trace_rec_t r);
    trace_rec_t m = r;
    if (!m.rd_vld) begin m.rd_addr = '0; m.rd_data = '0; end
    if (!m.m_vld)  begin m.m_addr = '0; m.m_data = '0; m.m_strb = '0; end
    return m;
  endfunction

  function automatic trace_rec_t mk(input logic gap, input logic [31:0] pc, input logic [31:0] instr,
                                    input logic rdv, input logic [5:0] rda, input logic [31:0] rdd,
                                    input logic mv, input logic [31:0] ma, input logic [31:0] md,
                                    input logic [3:0] ms);
    trace_rec_t r;
    r = '{gap, pc, instr, rdv, rda, rdd, mv, ma, md, ms};
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    bus.ivalid = 1'b1;
    bus.pc     = pc;
    bus.instr  = instr;
    tick();
    bus.ivalid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input trace_rec_t exp);
    check({tag, ".valid"}, 256'(bus.out_valid), 256'(1));
    check({tag, ".rec"}, 256'(mask(bus.out_rec)), 256'(mask(exp)));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.clr = 1'b0; bus.ivalid = 1'b0;
    bus.pc = '0; bus.instr = '0;
    bus.rd_write = 1'b0; bus.rd_waddr = '0; bus.rd_wdata = '0;
    bus.mvalid = 1'b0; bus.mwrite = 1'b0; bus.maddr = '0; bus.mdata = '0; bus.mstrb = '0;
    bus.out_ready = 1'b0;

    tick(); tick();
    check("rst.valid", 256'(bus.out_valid), 256'(0));
    check("rst.rec",   256'(bus.out_rec),   256'(0));
    check("rst.drop",  256'(bus.drop_cnt),  256'(0));
    check("rst.ovf",   256'(bus.overflow),  256'(0));
    reset = 1'b1;
    bus.en = 1'b1;
    tick();

    // Single retire: no fall-through in the commit cycle, valid one cycle later.
    bus.ivalid = 1'b1; bus.pc = 32'h8000_0000; bus.instr = 32'h0000_0013;
    #1;
    check("t1.nofall", 256'(bus.out_valid), 256'(0));
    tick();
    bus.ivalid = 1'b0;
    pop_expect("t1", mk(1'b0, 32'h8000_0000, 32'h0000_0013, 1'b0, '0, '0, 1'b0, '0, '0, '0));
    check("t1.empty", 256'(bus.out_valid), 256'(0));

    // rd latched before A, bypassed with B, absent for C.
    bus.rd_write = 1'b1; bus.rd_waddr = 6'd5; bus.rd_wdata = 32'h1234;
    tick();
    bus.rd_write = 1'b0;
    retire(32'h8000_0004, 32'h0010_0293);
    bus.rd_write = 1'b1; bus.rd_waddr = 6'd6; bus.rd_wdata = 32'hBEEF;
    retire(32'h8000_0008, 32'h0020_0313);
    bus.rd_write = 1'b0;
    retire(32'h8000_000C, 32'h0000_0013);
    pop_expect("t2.A", mk(1'b0, 32'h8000_0004, 32'h0010_0293, 1'b1, 6'd5, 32'h1234, 1'b0, '0, '0, '0));
    pop_expect("t2.B", mk(1'b0, 32'h8000_0008, 32'h0020_0313, 1'b1, 6'd6, 32'hBEEF, 1'b0, '0, '0, '0));
    pop_expect("t2.C", mk(1'b0, 32'h8000_000C, 32'h0000_0013, 1'b0, '0, '0, 1'b0, '0, '0, '0));

    // Store captured; a later load is not.
    bus.mvalid = 1'b1; bus.mwrite = 1'b1; bus.maddr = 32'h100; bus.mdata = 32'hA5A5_A5A5; bus.mstrb = 4'h3;
    tick();
    bus.mvalid = 1'b0; bus.mwrite = 1'b0;
    retire(32'h8000_0010, 32'h0051_1023);
    bus.mvalid = 1'b1; bus.maddr = 32'h200;
    tick();
    bus.mvalid = 1'b0;
    retire(32'h8000_0014, 32'h0001_2283);
    pop_expect("t3.st", mk(1'b0, 32'h8000_0010, 32'h0051_1023, 1'b0, '0, '0, 1'b1, 32'h100, 32'hA5A5_A5A5, 4'h3));
    pop_expect("t3.ld", mk(1'b0, 32'h8000_0014, 32'h0001_2283, 1'b0, '0, '0, 1'b0, '0, '0, '0));

    // Overflow: 20 back-to-back retires into 16 slots.
    for (int i = 0; i < 20; i++) begin
      bus.ivalid = 1'b1; bus.pc = 32'h1000 + 32'(4*i); bus.instr = 32'h13;
      tick();
    end
    bus.ivalid = 1'b0;
    check("t4.count", 256'(dut.u_fifo.o_count), 256'(16));
    check("t4.drop",  256'(bus.drop_cnt), 256'(4));
    check("t4.ovf",   256'(bus.overflow), 256'(1));
    for (int i = 0; i < 16; i++)
      pop_expect($sformatf("t4.drain%0d", i), mk(1'b0, 32'h1000 + 32'(4*i), 32'h13, 1'b0, '0, '0, 1'b0, '0, '0, '0));
    check("t4.empty", 256'(bus.out_valid), 256'(0));
    retire(32'h2000, 32'h13);
    retire(32'h2004, 32'h13);
    pop_expect("t4.gap1", mk(1'b1, 32'h2000, 32'h13, 1'b0, '0, '0, 1'b0, '0, '0, '0));
    pop_expect("t4.gap0", mk(1'b0, 32'h2004, 32'h13, 1'b0, '0, '0, 1'b0, '0, '0, '0));

    // Full FIFO: retire with a simultaneous pop is accepted, not dropped.
    for (int i = 0; i < 16; i++) retire(32'h2100 + 32'(4*i), 32'h13);
    check("t5.full", 256'(dut.u_fifo.o_count), 256'(16));
    bus.ivalid = 1'b1; bus.pc = 32'h3000; bus.out_ready = 1'b1;
    tick();
    bus.ivalid = 1'b0; bus.out_ready = 1'b0;
    check("t5.count", 256'(dut.u_fifo.o_count), 256'(16));
    check("t5.drop",  256'(bus.drop_cnt), 256'(4));
    check("t5.head",  256'(bus.out_rec.pc), 256'(32'h2104));

    // Async reset with 5 held records.
    bus.out_ready = 1'b1;
    repeat (11) tick();
    bus.out_ready = 1'b0;
    check("t6.held", 256'(dut.u_fifo.o_count), 256'(5));
    #3 reset = 1'b0;
    #1;
    check("t6.valid", 256'(bus.out_valid), 256'(0));
    check("t6.drop",  256'(bus.drop_cnt), 256'(0));
    check("t6.ovf",   256'(bus.overflow), 256'(0));
    check("t6.rec",   256'(bus.out_rec),  256'(0));
    reset = 1'b1;
    tick();

    // Flush wins over a same-cycle push.
    retire(32'h4000, 32'h13);
    retire(32'h4004, 32'h13);
    bus.clr = 1'b1; bus.ivalid = 1'b1; bus.pc = 32'h4008;
    tick();
    bus.clr = 1'b0; bus.ivalid = 1'b0;
    check("t6.clr.valid", 256'(bus.out_valid), 256'(0));
    check("t6.clr.count", 256'(dut.u_fifo.o_count), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
